// File: rtl/pb_bridge_pkg.sv
// Shared definitions for the PicoBlaze sample/interrupt bridge: FSM encoding,
// processor port address and overflow counter saturation value.
package pb_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IRQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  localparam logic [7:0] PORT0_ADDR = 8'h00;
  localparam logic [7:0] OVF_SAT    = 8'hFF;

endpackage

// File: rtl/sync_fifo_byte.sv
// Single-clock byte FIFO with a separate occupancy counter; head data is
// read combinationally so a pop and a push may share a cycle even when full.
module sync_fifo_byte #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_i && !pop_i)      level_d = level_q + 1'b1;
    else if (pop_i && !push_i) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/pb_sample_irq_bridge.sv
// Converts signed audio samples to 8-bit magnitudes, queues them and hands
// them one at a time to the PicoBlaze through an interrupt/ack/read handshake.
module pb_sample_irq_bridge
  import pb_bridge_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]       sample_data,
  input  logic                          interrupt_ack,
  input  logic                          rd_strobe,
  output logic                          interrupt,
  output logic [7:0]                    input_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    overflow_count
);

  localparam int unsigned SW = SAMPLE_WIDTH;

  state_e        state_q, state_d;
  logic          interrupt_q;
  logic [7:0]    input_data_q, input_data_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [SW-1:0] mag;
  logic [7:0]    mag_byte;
  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;

  // Most negative sample has no positive counterpart; clamp it to full scale.
  always_comb begin
    if (sample_data == {1'b1, {(SW-1){1'b0}}})
      mag = {1'b0, {(SW-1){1'b1}}};
    else if (sample_data[SW-1])
      mag = -sample_data;
    else
      mag = sample_data;
  end

  assign mag_byte = 8'(mag >> (SW - 9));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_IRQ;
        end
      end
      S_IRQ:     if (interrupt_ack) state_d = S_SERVICE;
      S_SERVICE: if (rd_strobe)     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign push         = sample_valid && (!fifo_full || pop);
  assign input_data_d = pop ? fifo_rdata : input_data_q;

  always_comb begin
    ovf_d = ovf_q;
    if (sample_valid && fifo_full && !pop && (ovf_q != OVF_SAT))
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      interrupt_q  <= 1'b0;
      input_data_q <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      interrupt_q  <= (state_d == S_IRQ);
      input_data_q <= input_data_d;
      ovf_q        <= ovf_d;
    end
  end

  sync_fifo_byte #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (mag_byte),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign interrupt      = interrupt_q;
  assign input_data     = input_data_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_pb_sample_irq_bridge.sv
// Self-checking bench for pb_sample_irq_bridge against a queue-based model.
module tb_pb_sample_irq_bridge;

  localparam int unsigned SW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          interrupt_ack = 1'b0;
  logic          rd_strobe = 1'b0;
  logic          interrupt;
  logic [7:0]    input_data;
  logic [LW-1:0] fifo_level;
  logic [7:0]    overflow_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of bytes, the byte shown to the processor, the
  // handshake phase (0 waiting for data, 1 interrupt raised, 2 being read).
  logic [7:0] m_q[$];
  logic [7:0] m_data;
  int         m_phase;
  int         m_ovf;

  pb_sample_irq_bridge #(
    .SAMPLE_WIDTH (SW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .interrupt_ack  (interrupt_ack),
    .rd_strobe      (rd_strobe),
    .interrupt      (interrupt),
    .input_data     (input_data),
    .fifo_level     (fifo_level),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mag_of(input logic [SW-1:0] s);
    longint v;
    longint maxv;
    v    = longint'($signed(s));
    maxv = (longint'(1) << (SW - 1)) - 1;
    if (v < 0) v = -v;
    if (v > maxv) v = maxv;
    return 8'((v >> (SW - 9)) & 255);
  endfunction

  function automatic logic [19:0] model_vec();
    return {(m_phase == 1), m_data, LW'(m_q.size()), 8'(m_ovf)};
  endfunction

  // Advance one clock: update the model from the inputs currently applied,
  // take the edge, then clear the single-cycle strobes.
  task automatic step();
    bit can_pop;
    bit was_full;
    can_pop  = (m_phase == 0) && (m_q.size() != 0);
    was_full = (m_q.size() == DEPTH);
    if (reset) begin
      m_q.delete();
      m_data  = 8'h00;
      m_phase = 0;
      m_ovf   = 0;
    end else begin
      if (can_pop) begin
        m_data  = m_q.pop_front();
        m_phase = 1;
      end else if (m_phase == 1 && interrupt_ack) begin
        m_phase = 2;
      end else if (m_phase == 2 && rd_strobe) begin
        m_phase = 0;
      end
      if (sample_valid) begin
        if (!was_full || can_pop) m_q.push_back(mag_of(sample_data));
        else if (m_ovf < 255) m_ovf++;
      end
    end
    @(posedge clk);
    #1;
    sample_valid  = 1'b0;
    interrupt_ack = 1'b0;
    rd_strobe     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if ({interrupt, input_data, fifo_level, overflow_count} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h",
               {interrupt, input_data, fifo_level, overflow_count}, 20'h0);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    sample_valid = 1'b1;
    sample_data  = 16'h4000;
    step();
    n_checks++;
    if (interrupt !== 1'b0 || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL single_write: irq=%b lvl=%0d expected irq=0 lvl=1", interrupt, fifo_level);
    end
    step();
    n_checks++;
    if (interrupt !== 1'b1 || input_data !== 8'h80 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop: irq=%b data=%h lvl=%0d expected irq=1 data=80 lvl=0",
               interrupt, input_data, fifo_level);
    end
    interrupt_ack = 1'b1;
    step();
    n_checks++;
    if (interrupt !== 1'b0 || input_data !== 8'h80) begin
      n_fail++;
      $display("FAIL single_ack: irq=%b data=%h expected irq=0 data=80", interrupt, input_data);
    end
    rd_strobe = 1'b1;
    step();
    step();
    n_checks++;
    if ({interrupt, input_data, fifo_level, overflow_count} !== model_vec()) begin
      n_fail++;
      $display("FAIL single_read: got %h expected %h",
               {interrupt, input_data, fifo_level, overflow_count}, model_vec());
    end
  endtask

  task automatic test_order();
    sample_valid = 1'b1;
    sample_data  = 16'h8000;
    step();
    sample_valid = 1'b1;
    sample_data  = 16'hFF80;
    step();
    n_checks++;
    if (interrupt !== 1'b1 || input_data !== 8'hFF || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL order_first: irq=%b data=%h lvl=%0d expected irq=1 data=ff lvl=1",
               interrupt, input_data, fifo_level);
    end
    for (int i = 0; i < 3; i++) step();
    interrupt_ack = 1'b1;
    step();
    rd_strobe = 1'b1;
    step();
    n_checks++;
    if (interrupt !== 1'b0 || input_data !== 8'hFF || fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL order_hold: irq=%b data=%h lvl=%0d expected irq=0 data=ff lvl=1",
               interrupt, input_data, fifo_level);
    end
    step();
    n_checks++;
    if (interrupt !== 1'b1 || input_data !== 8'h01 || fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL order_second: irq=%b data=%h lvl=%0d expected irq=1 data=01 lvl=0",
               interrupt, input_data, fifo_level);
    end
    interrupt_ack = 1'b1;
    step();
    rd_strobe = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_valid = 1'b1;
      sample_data  = SW'($urandom);
      step();
      n_checks++;
      if ({interrupt, input_data, fifo_level, overflow_count} !== model_vec()) begin
        n_fail++;
        $display("FAIL burst_%0d: got %h expected %h", i,
                 {interrupt, input_data, fifo_level, overflow_count}, model_vec());
      end
    end
    n_checks++;
    if (fifo_level !== 3'd4 || overflow_count !== 8'd1 || interrupt !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_drop: lvl=%0d ovf=%0d irq=%b expected lvl=4 ovf=1 irq=1",
               fifo_level, overflow_count, interrupt);
    end
  endtask

  task automatic test_full_pop();
    interrupt_ack = 1'b1;
    step();
    rd_strobe = 1'b1;
    step();
    sample_valid = 1'b1;
    sample_data  = SW'($urandom);
    step();
    n_checks++;
    if (fifo_level !== 3'd4 || overflow_count !== 8'd1 || interrupt !== 1'b1 ||
        input_data !== m_data) begin
      n_fail++;
      $display("FAIL full_pop: lvl=%0d ovf=%0d irq=%b data=%h expected lvl=4 ovf=1 irq=1 data=%h",
               fifo_level, overflow_count, interrupt, input_data, m_data);
    end
  endtask

  task automatic test_rd_in_irq();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 16'h1234;
    step();
    step();
    rd_strobe = 1'b1;
    step();
    n_checks++;
    if (interrupt !== 1'b1 || input_data !== 8'h24) begin
      n_fail++;
      $display("FAIL rd_in_irq: irq=%b data=%h expected irq=1 data=24", interrupt, input_data);
    end
    interrupt_ack = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample_data  = SW'($urandom);
      interrupt_ack = 1'b1;
      step();
      step();
    end
    n_checks++;
    if (fifo_level !== 3'd3 || interrupt !== 1'b0 || input_data !== 8'h24) begin
      n_fail++;
      $display("FAIL service_queue: lvl=%0d irq=%b data=%h expected lvl=3 irq=0 data=24",
               fifo_level, interrupt, input_data);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if ({interrupt, input_data, fifo_level, overflow_count} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_in_service: got %h expected %h",
               {interrupt, input_data, fifo_level, overflow_count}, 20'h0);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1;
      sample_data  = SW'($urandom);
      step();
    end
    n_checks++;
    if (overflow_count !== 8'd255 || fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_saturate: ovf=%0d lvl=%0d expected ovf=255 lvl=4",
               overflow_count, fifo_level);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 399) == 0);
      sample_valid  = ($urandom_range(0, 2) == 0);
      sample_data   = ($urandom_range(0, 9) == 0) ? {1'b1, {(SW-1){1'b0}}} : SW'($urandom);
      interrupt_ack = ($urandom_range(0, 3) == 0);
      rd_strobe     = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if ({interrupt, input_data, fifo_level, overflow_count} !== model_vec()) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle_%0d: got %h expected %h", i,
                   {interrupt, input_data, fifo_level, overflow_count}, model_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_data  = 8'h00;
    m_phase = 0;
    m_ovf   = 0;
    test_reset();
    test_single();
    test_order();
    test_back_to_back();
    test_full_pop();
    test_rd_in_irq();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
